// File: rtl/silly_checker.sv
`default_nettype none
// ============================================================================
// Module   : silly_checker
// Brief    : Samples a 3-input DUT's inputs and output on a fixed vector
//            period and checks y against a programmable 8-entry truth table.
// Revision : 1.0 - initial release
// ============================================================================
module silly_checker #(
  parameter int PERIOD  = 2,
  parameter int NUM_VEC = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       truth_table,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [7:0]       coverage,
  output logic             first_fail_valid,
  output logic [2:0]       first_fail_idx,
  output logic             first_fail_y
);

  localparam int TMR_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  // vec_count may wrap for narrow CNT_W, so run length is tracked separately
  localparam int SMP_W = $clog2(NUM_VEC + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [SMP_W-1:0]   smp_q, smp_d;
  logic [CNT_W-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [7:0]         cov_q, cov_d;
  logic               ffv_q, ffv_d;
  logic [2:0]         ffi_q, ffi_d;
  logic               ffy_q, ffy_d;
  logic [2:0]         w_idx;
  logic               w_exp;
  logic [SMP_W-1:0]   w_smp_inc;

  assign w_idx     = {a, b, c};
  assign w_exp     = truth_table[w_idx];
  assign w_smp_inc = smp_q + SMP_W'(1);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    smp_d   = smp_q;
    vec_d   = vec_q;
    err_d   = err_q;
    cov_d   = cov_q;
    ffv_d   = ffv_q;
    ffi_d   = ffi_q;
    ffy_d   = ffy_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        timer_d = '0;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = ST_RUN;
          smp_d   = '0;
          vec_d   = '0;
          err_d   = '0;
          cov_d   = '0;
          ffv_d   = 1'b0;
          ffi_d   = '0;
          ffy_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (timer_q == TMR_W'(PERIOD - 1)) begin
          timer_d       = '0;
          smp_d         = w_smp_inc;
          vec_d         = vec_q + CNT_W'(1);
          cov_d[w_idx]  = 1'b1;
          if (y != w_exp) begin
            if (err_q != {CNT_W{1'b1}}) begin
              err_d = err_q + CNT_W'(1);
            end
            if (!ffv_q) begin
              ffv_d = 1'b1;
              ffi_d = w_idx;
              ffy_d = y;
            end
          end
          if (w_smp_inc == SMP_W'(NUM_VEC)) begin
            state_d = ST_DONE;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      smp_q   <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      cov_q   <= '0;
      ffv_q   <= 1'b0;
      ffi_q   <= '0;
      ffy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      smp_q   <= smp_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      cov_q   <= cov_d;
      ffv_q   <= ffv_d;
      ffi_q   <= ffi_d;
      ffy_q   <= ffy_d;
    end
  end

  assign busy             = (state_q == ST_RUN);
  assign done             = (state_q == ST_DONE);
  assign pass             = done && (err_q == '0) && (cov_q == 8'hFF);
  assign vec_count        = vec_q;
  assign err_count        = err_q;
  assign coverage         = cov_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_idx   = ffi_q;
  assign first_fail_y     = ffy_q;

endmodule
`default_nettype wire

// File: tb/tb_silly_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_silly_checker
// Brief    : Scoreboard bench for silly_checker, default and narrow/PERIOD=1 builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_silly_checker;

  typedef struct packed {
    logic [15:0] vec;
    logic [15:0] err;
    logic [7:0]  cov;
    logic        ffv;
    logic [2:0]  ffi;
    logic        ffy;
    logic        done;
    logic        pass;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n, abort, start0, start1, a, b, c, y0, y1;
  logic [7:0] tt;

  logic        busy0, done0, pass0, ffv0, ffy0;
  logic [15:0] vec0, err0;
  logic [7:0]  cov0;
  logic [2:0]  ffi0;
  logic        busy1, done1, pass1, ffv1, ffy1;
  logic [2:0]  vec1, err1;
  logic [7:0]  cov1;
  logic [2:0]  ffi1;

  int sel = 0;
  logic        o_busy, o_done, o_pass, o_ffv, o_ffy;
  logic [15:0] o_vec, o_err;
  logic [7:0]  o_cov;
  logic [2:0]  o_ffi;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  int   m_vec, m_err, m_maxv;
  logic [7:0] m_cov;
  logic m_ffv, m_ffy;
  logic [2:0] m_ffi;

  always #5 clk = ~clk;

  silly_checker u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .abort(abort), .truth_table(tt),
    .a(a), .b(b), .c(c), .y(y0), .busy(busy0), .done(done0), .pass(pass0),
    .vec_count(vec0), .err_count(err0), .coverage(cov0), .first_fail_valid(ffv0),
    .first_fail_idx(ffi0), .first_fail_y(ffy0)
  );

  silly_checker #(.PERIOD(1), .NUM_VEC(12), .CNT_W(3)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .abort(abort), .truth_table(tt),
    .a(a), .b(b), .c(c), .y(y1), .busy(busy1), .done(done1), .pass(pass1),
    .vec_count(vec1), .err_count(err1), .coverage(cov1), .first_fail_valid(ffv1),
    .first_fail_idx(ffi1), .first_fail_y(ffy1)
  );

  always_comb begin
    o_busy = busy0; o_done = done0; o_pass = pass0; o_vec = vec0; o_err = err0;
    o_cov  = cov0;  o_ffv  = ffv0;  o_ffi  = ffi0;  o_ffy = ffy0;
    if (sel == 1) begin
      o_busy = busy1; o_done = done1; o_pass = pass1;
      o_vec  = {13'd0, vec1}; o_err = {13'd0, err1};
      o_cov  = cov1; o_ffv = ffv1; o_ffi = ffi1; o_ffy = ffy1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: correct; 1: y forced 0 at idx 3; 2: inputs held 000; 3: y inverted
  task automatic drive_vec(input int n, input int nvec, input int mode);
    logic [2:0] idx;
    logic       good, yv;
    exp_t       e;
    idx  = (mode == 2) ? 3'd0 : 3'(n % 8);
    good = tt[idx];
    yv   = good;
    if (mode == 1 && idx == 3'd3) yv = 1'b0;
    if (mode == 3) yv = ~good;
    {a, b, c} = idx;
    if (sel == 1) y1 = yv; else y0 = yv;
    m_vec = (m_vec + 1) & m_maxv;
    m_cov[idx] = 1'b1;
    if (yv != good) begin
      if (m_err < m_maxv) m_err++;
      if (!m_ffv) begin
        m_ffv = 1'b1; m_ffi = idx; m_ffy = yv;
      end
    end
    e.vec  = 16'(m_vec);
    e.err  = 16'(m_err);
    e.cov  = m_cov;
    e.ffv  = m_ffv;
    e.ffi  = m_ffi;
    e.ffy  = m_ffy;
    e.done = (n + 1 == nvec);
    e.pass = e.done && (m_err == 0) && (m_cov == 8'hFF);
    sb.push_back(e);
  endtask

  task automatic run(input int s, input int nvec, input int mode, input int stop_after,
                     input int period, input int cntw);
    exp_t e;
    sel = s;
    m_vec = 0; m_err = 0; m_maxv = (1 << cntw) - 1;
    m_cov = '0; m_ffv = 1'b0; m_ffi = '0; m_ffy = 1'b0;
    sb.delete();
    @(negedge clk);
    if (s == 1) start1 = 1'b1; else start0 = 1'b1;
    drive_vec(0, nvec, mode);
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    chk("busy_after_start", 32'(o_busy), 32'd1);
    chk("cleared_vec", 32'(o_vec), 32'd0);
    chk("cleared_ffv", 32'(o_ffv), 32'd0);
    for (int n = 0; n < nvec; n++) begin
      repeat (period) @(posedge clk);
      @(negedge clk);
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk("vec_count", 32'(o_vec), 32'(e.vec));
        chk("err_count", 32'(o_err), 32'(e.err));
        chk("coverage", 32'(o_cov), 32'(e.cov));
        chk("ff_valid", 32'(o_ffv), 32'(e.ffv));
        if (e.ffv) begin
          chk("ff_idx", 32'(o_ffi), 32'(e.ffi));
          chk("ff_y", 32'(o_ffy), 32'(e.ffy));
        end
        chk("done", 32'(o_done), 32'(e.done));
        chk("pass", 32'(o_pass), 32'(e.pass));
      end
      if (n + 1 == stop_after) return;
      if (n + 1 < nvec) drive_vec(n + 1, nvec, mode);
    end
    // statistics must hold in DONE regardless of input activity
    {a, b, c} = 3'b101;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("hold_done", 32'(o_done), 32'd1);
    chk("hold_vec", 32'(o_vec), 32'(m_vec));
  endtask

  initial begin
    reset_n = 1'b0; abort = 1'b0; start0 = 1'b0; start1 = 1'b0;
    a = 1'b0; b = 1'b0; c = 1'b0; y0 = 1'b0; y1 = 1'b0;
    tt = 8'hE8;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_done", 32'(o_done), 32'd0);
      chk("rst_vec", 32'(o_vec), 32'd0);
      chk("rst_err", 32'(o_err), 32'd0);
      chk("rst_cov", 32'(o_cov), 32'd0);
      chk("rst_ffv", 32'(o_ffv), 32'd0);
    end
    reset_n = 1'b1;

    run(0, 8, 0, -1, 2, 16);   // exhaustive majority
    run(0, 8, 1, -1, 2, 16);   // injected fault at idx 3
    run(0, 8, 2, -1, 2, 16);   // partial coverage

    run(0, 8, 0, 3, 2, 16);    // abort after 3 samples, at edge S+7
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_done", 32'(o_done), 32'd0);
    chk("abort_vec", 32'(o_vec), 32'd3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_idle_hold", 32'(o_vec), 32'd3);
    run(0, 8, 0, -1, 2, 16);

    run(0, 8, 1, 4, 2, 16);    // reset at edge S+9 with start asserted
    chk("pre_reset_ffv", 32'(o_ffv), 32'd1);
    reset_n = 1'b0;
    start0  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_busy", 32'(o_busy), 32'd0);
    chk("mrst_vec", 32'(o_vec), 32'd0);
    chk("mrst_err", 32'(o_err), 32'd0);
    chk("mrst_cov", 32'(o_cov), 32'd0);
    chk("mrst_ffv", 32'(o_ffv), 32'd0);
    chk("mrst_ffi", 32'(o_ffi), 32'd0);
    reset_n = 1'b1;
    start0  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_stay_idle", 32'(o_busy), 32'd0);

    run(1, 12, 3, -1, 1, 3);   // saturation, wrap, PERIOD=1

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
